// File: rtl/modulation_pkg.sv
`default_nettype none
// ============================================================================
// Package : modulation_pkg
// Shared types, constants and the Gray mapping for the segment-3 modem.
// Rev 1.0 : initial release
// ============================================================================
package modulation_pkg;

  localparam int NUM_SEG = 10;
  localparam int WIDTH   = 32;
  localparam int LATENCY = 3;
  localparam int IDX_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } mod_state_e;

  typedef logic [WIDTH-1:0] word_t;

  // Forward Gray mapping; the receive side inverts this.
  function automatic word_t gray_map(input word_t word);
    return word ^ (word >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/modulation_segment_3_with_control_if.sv
`default_nettype none
// ============================================================================
// Interface : modulation_segment_3_with_control_if
// Payload, control request and modulated output of the segment-3 modulator.
// Rev 1.0 : initial release
// ============================================================================
interface modulation_segment_3_with_control_if;
  import modulation_pkg::*;

  word_t segment_0;
  word_t segment_1;
  word_t segment_2;
  word_t segment_3;
  word_t segment_4;
  word_t segment_5;
  word_t segment_6;
  word_t segment_7;
  word_t segment_8;
  word_t segment_9;
  logic  start;
  word_t output_bit;
  logic  valid;
  logic  busy;
  logic  done;

  modport master (
    output segment_0, segment_1, segment_2, segment_3, segment_4,
           segment_5, segment_6, segment_7, segment_8, segment_9, start,
    input  output_bit, valid, busy, done
  );

  modport slave (
    input  segment_0, segment_1, segment_2, segment_3, segment_4,
           segment_5, segment_6, segment_7, segment_8, segment_9, start,
    output output_bit, valid, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/modulation_gray_pipe.sv
`default_nettype none
// ============================================================================
// Module : modulation_gray_pipe
// Three-stage register / Gray-map / register pipeline with per-stage valid
// bits and a synchronous flush. Data is forced to zero behind a clear valid
// so the output word is 0 whenever out_valid is low.
// Rev 1.0 : initial release
// ============================================================================
module modulation_gray_pipe
  import modulation_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  flush,
  input  logic  in_valid,
  input  word_t in_data,
  output logic  out_valid,
  output word_t out_data
);

  logic  s1_v, s2_v, s3_v;
  word_t s1_d, s2_d, s3_d;

  // Advance all three stages each cycle; flush empties the whole pipe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
      s1_d <= '0;
      s2_d <= '0;
      s3_d <= '0;
    end else if (flush) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
      s1_d <= '0;
      s2_d <= '0;
      s3_d <= '0;
    end else begin
      s1_v <= in_valid;
      s1_d <= in_valid ? in_data : '0;
      s2_v <= s1_v;
      s2_d <= s1_v ? gray_map(s1_d) : '0;
      s3_v <= s2_v;
      s3_d <= s2_v ? s2_d : '0;
    end
  end

  assign out_valid = s3_v;
  assign out_data  = s3_d;

endmodule
`default_nettype wire

// File: rtl/modulation_segment_3_with_control.sv
`default_nettype none
// ============================================================================
// Module : modulation_segment_3_with_control
// Captures ten segments on start and streams their Gray-mapped words out one
// per cycle through a 3-stage pipeline; level start, busy, valid, done pulse.
// Rev 1.0 : initial release
// ============================================================================
module modulation_segment_3_with_control
  import modulation_pkg::*;
(
  input logic clk,
  input logic reset_n,
  modulation_segment_3_with_control_if.slave bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_HOLD  = HOLD;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SEG - 1);
  localparam logic [1:0]       DRAIN_END = 2'(LATENCY - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [1:0]       drain_cnt;
  logic             done_r;
  word_t            seg_buf [NUM_SEG];
  word_t            seg_in  [NUM_SEG];

  logic capture;
  logic issue;
  logic flush;

  // Gather the explicit segment ports into an indexable array.
  always_comb begin
    seg_in[0] = bus.segment_0;
    seg_in[1] = bus.segment_1;
    seg_in[2] = bus.segment_2;
    seg_in[3] = bus.segment_3;
    seg_in[4] = bus.segment_4;
    seg_in[5] = bus.segment_5;
    seg_in[6] = bus.segment_6;
    seg_in[7] = bus.segment_7;
    seg_in[8] = bus.segment_8;
    seg_in[9] = bus.segment_9;
  end

  assign capture = (state == S_IDLE) && bus.start;
  assign issue   = (state == S_RUN) && bus.start;
  // Dropping start mid-transaction aborts and empties the pipe on the same edge.
  assign flush   = ((state == S_RUN) || (state == S_DRAIN)) && !bus.start;

  // Control FSM: capture, issue ten words, wait for the pipe to empty, hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      drain_cnt <= '0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_RUN;
            idx   <= '0;
          end
        end
        S_RUN: begin
          if (!bus.start) begin
            state <= S_IDLE;
            idx   <= '0;
          end else if (idx == LAST_IDX) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DRAIN: begin
          if (!bus.start) begin
            state <= S_IDLE;
            idx   <= '0;
          end else if (drain_cnt == DRAIN_END) begin
            state  <= S_HOLD;
            done_r <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          // A start still held from the last transaction must not retrigger.
          if (!bus.start) begin
            state <= S_IDLE;
            idx   <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // Segment buffer loads only on the IDLE-to-RUN edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SEG; i++) seg_buf[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < NUM_SEG; i++) seg_buf[i] <= seg_in[i];
    end
  end

  modulation_gray_pipe u_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (issue),
    .in_data   (seg_buf[idx]),
    .out_valid (bus.valid),
    .out_data  (bus.output_bit)
  );

  assign bus.busy = (state == S_RUN) || (state == S_DRAIN);
  assign bus.done = done_r;

endmodule
`default_nettype wire

// File: doc/modulation_segment_3_with_control.md
# modulation_segment_3_with_control

Transmit-side counterpart of the segment-3 demodulator. Captures ten 32-bit segments on `start` and streams them out, one modulated word per cycle, through a fixed 3-stage mapping pipeline. Word k is the Gray mapping `segment_k ^ (segment_k >> 1)`. Uses the same level-held `start` / `valid` / `busy` control style as the demodulation side, with an added one-cycle `done` pulse.

## Interface
- `NUM_SEG`, 10, number of segments per transaction (fixed at 10; ports are explicit)
- `WIDTH`, 32, segment and output word width
- `LATENCY`, 3, cycles from word issue to word on `output_bit`
- `clk`  in  1  rising-edge clock; the block has one clock
- `reset_n`  in  1  asynchronous, active-low reset
- `segment_0` … `segment_9`  in  32 each  payload words, sampled only at transaction start
- `start`  in  1  level request; must stay high for the whole transaction
- `output_bit`  out  32  modulated word; 0 whenever `valid`=0
- `valid`  out  1  `output_bit` carries word k this cycle
- `busy`  out  1  transaction in progress (states RUN or DRAIN)
- `done`  out  1  one-cycle pulse after the last word

## Operation
- States: IDLE, RUN, DRAIN, HOLD.
- **IDLE**
  - `start`=1 at an edge: latch all ten segments into an internal buffer, clear `idx` to 0, go to RUN.
  - `start`=0: stay in IDLE.
- **RUN**
  - Each edge issues `buf[idx]` into pipeline stage 1 with its valid bit set, then increments `idx`.
  - After issuing `idx`=9, go to DRAIN.
- **DRAIN**
  - Stays until the last word has left stage 3 (LATENCY-1 = 2 cycles), then goes to HOLD.
- **HOLD**
  - `done`=1 for the single cycle after entry.
  - Stays in HOLD while `start`=1, so a held `start` cannot retrigger.
  - `start`=0: go to IDLE.
- **Pipeline**
  - Stage 1: register the buffer word.
  - Stage 2: `g = s1 ^ (s1 >> 1)`, a logical shift with zero fill.
  - Stage 3: register `g` into `output_bit`.
  - Each stage carries its own valid bit; `valid` is the stage-3 valid bit.
- **Abort:** `start`=0 in RUN or DRAIN → next edge: state IDLE, all pipeline valid bits cleared, `output_bit`=0, no `done`.
- **Input isolation:** segment inputs are ignored outside the IDLE→RUN capture edge.
- **Widths:** no arithmetic widening. `idx` is 4 bits and never exceeds 9.

## Timing
- **Reset values:** `output_bit`=0, `valid`=0, `busy`=0, `done`=0, state IDLE, `idx`=0, buffer and pipeline cleared. Reset takes effect immediately, mid-transaction included.
- Let E0 be the edge where `start` is seen high in IDLE. `busy`=1 from E0.
- Word k is issued at E(k+1) and is on `output_bit` with `valid`=1 after E(k+3), for k = 0..9.
- `valid` is high for exactly 10 consecutive cycles: after E3 through after E12.
- `busy` falls and `done` pulses after E13; HOLD is entered at E13.
- `valid` and `done` are never high in the same cycle.
- **Back-to-back:** the minimum gap is one cycle with `start`=0 (HOLD→IDLE) before `start` is re-raised.
- **Abort:** `start` low sampled at edge En in RUN or DRAIN → `valid`, `busy` and `output_bit` are 0 after En.

## Structure
- **Shared package `modulation_pkg`:**
  - state enum (IDLE/RUN/DRAIN/HOLD)
  - constants NUM_SEG=10, WIDTH=32, LATENCY=3
  - function `gray_map(word)`; the demodulator side reuses this package for the inverse mapping
- **Sub-module `modulation_gray_pipe`:**
  - 3-stage data plus valid pipeline, with a synchronous flush input driven on abort
- **Top level** holds the FSM, segment buffer and `idx` counter.

## Test plan
- **Basic:** `segment_k` = k+1, `start` held.
  - `valid` after E3..E12; `output_bit` = 1,3,2,6,7,5,4,12,13,15.
  - `done` pulses after E13.
- **All-ones:** all segments = 0xFFFFFFFF → ten words of 0x80000000; `busy` high E0..E12.
- **Input isolation:** after E0, change all segments to 0xDEADBEEF.
  - Outputs still match the basic sequence; no value derived from 0xDEADBEEF appears.
- **Abort:** drop `start` before E6 → after E6: `valid`=0, `output_bit`=0, `busy`=0, no `done`.
  - Exactly words 0–2 were emitted.
- **Re-arm:** keep `start` high for 5 cycles after `done` → no new `valid`.
  - Drop `start` one cycle, raise it again → a second full 10-word sequence with new segment values.
- **Reset:** pull `reset_n` low asynchronously during DRAIN (after E11) → all outputs 0 immediately.
  - After release with `start`=1, a fresh transaction starts.
